// File: rtl/laser_tx_serializer.sv
// On/off-keyed laser frame serializer: pops one byte from the upstream queue and sends
// start, 8 data bits LSB first, optional even parity and stop bit(s), CLKS_PER_BIT clocks each.
module laser_tx_serializer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [7:0]  q_data,
  input  logic        q_empty,
  output logic        q_read,
  output logic        laser_out,
  output logic        busy,
  output logic [15:0] frames_sent
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [2:0]    bit_q, bit_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          laser_q, laser_d;
  logic [15:0]   frames_q, frames_d;
  logic          bit_end;

  assign bit_end     = (cnt_q == CNT_LAST);
  assign laser_out   = laser_q;
  assign busy        = (state_q != S_IDLE);
  assign frames_sent = frames_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      parity_q <= 1'b0;
      bit_q    <= '0;
      cnt_q    <= '0;
      laser_q  <= 1'b0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
      laser_q  <= laser_d;
      frames_q <= frames_d;
    end
  end

  // laser_d always carries the bit value of the state being entered, so the
  // registered laser output lines up with the state register.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
    laser_d  = 1'b0;
    frames_d = frames_q;
    q_read   = 1'b0;

    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (reset_n && enable && !q_empty) begin
          q_read   = 1'b1;
          shift_d  = q_data;
          parity_d = ^q_data;
          state_d  = S_START;
          laser_d  = 1'b1;
        end
      end
      S_START: begin
        laser_d = 1'b1;
        if (bit_end) begin
          state_d = S_DATA;
          laser_d = shift_q[0];
        end
      end
      S_DATA: begin
        laser_d = shift_q[0];
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          laser_d = shift_q[1];
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
            bit_d = '0;
            if (PARITY_EN) begin
              state_d = S_PARITY;
              laser_d = parity_q;
            end else begin
              state_d = S_STOP;
              laser_d = 1'b0;
            end
          end
        end
      end
      S_PARITY: begin
        laser_d = parity_q;
        if (bit_end) begin
          state_d = S_STOP;
          laser_d = 1'b0;
        end
      end
      S_STOP: begin
        // bit_q counts stop periods here
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            state_d  = S_IDLE;
            bit_d    = '0;
            frames_d = frames_q + 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
